// File: rtl/piso_serializer.sv
// Multi-channel PISO serializer with self-generated ser_clk and trailing latch strobe (PISO_LSB_FIRST_EN: LSB-first shift).
// Latency: a word accepted on edge E finishes its last LATCH cycle 2*HALF_PERIOD*WIDTH+HALF_PERIOD cycles later; done follows.
// Backpressure: load_ready is high only in IDLE with abort low, so one word is in flight; back-to-back leaves one IDLE cycle.
module piso_serializer #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 1,
  parameter int HALF_PERIOD = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] par_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      abort,
  output logic [CHANNELS-1:0]       ser_out,
  output logic                      ser_clk,
  output logic                      latch,
  output logic                      done
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_INIT = BW'(WIDTH);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [PW-1:0]                    phase_q, phase_d;
  logic [BW-1:0]                    bit_cnt_q, bit_cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   shreg_q, shreg_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   shreg_shift;
  logic                             ser_clk_q, ser_clk_d;
  logic                             latch_q, latch_d;
  logic                             done_q, done_d;
  logic                             phase_last;
  logic                             accept;

  assign load_ready = (state_q == IDLE) && !abort;
  assign accept     = load_valid && load_ready;
  assign phase_last = (phase_q == PH_LAST);

  // Each channel register advances one position, zero filled, toward its output end.
  always_comb begin
    shreg_shift = '0;
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef PISO_LSB_FIRST_EN
      shreg_shift[c] = {1'b0, shreg_q[c][WIDTH-1:1]};
`else
      shreg_shift[c] = {shreg_q[c][WIDTH-2:0], 1'b0};
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (accept) begin
          shreg_d   = par_in;
          bit_cnt_d = BIT_INIT;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // Shift on the last HIGH cycle so the new bit appears with the falling edge.
        if (phase_last) begin
          phase_d   = '0;
          shreg_d   = shreg_shift;
          bit_cnt_d = bit_cnt_q - BIT_ONE;
          state_d   = (bit_cnt_q == BIT_ONE) ? LATCH : LOW;
        end
      end
      LATCH: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      phase_d   = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
      done_d    = 1'b0;
    end

    ser_clk_d = (state_d == HIGH);
    latch_d   = (state_d == LATCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ser_clk_q <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ser_clk_q <= ser_clk_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    ser_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef PISO_LSB_FIRST_EN
      ser_out[c] = shreg_q[c][0];
`else
      ser_out[c] = shreg_q[c][WIDTH-1];
`endif
    end
  end

  assign ser_clk = ser_clk_q;
  assign latch   = latch_q;
  assign done    = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializer instances (8x1 /1 and 4x3 /3); expected bits, latch and done times are queued by stimulus.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [7:0]  par_in_a;
  logic        load_valid_a, load_ready_a, abort_a;
  logic [0:0]  ser_out_a;
  logic        ser_clk_a, latch_a, done_a;
  logic [11:0] par_in_b;
  logic        load_valid_b, load_ready_b, abort_b;
  logic [2:0]  ser_out_b;
  logic        ser_clk_b, latch_b, done_b;

  piso_serializer #(.WIDTH(8), .CHANNELS(1), .HALF_PERIOD(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .par_in(par_in_a), .load_valid(load_valid_a),
    .load_ready(load_ready_a), .abort(abort_a), .ser_out(ser_out_a),
    .ser_clk(ser_clk_a), .latch(latch_a), .done(done_a));

  piso_serializer #(.WIDTH(4), .CHANNELS(3), .HALF_PERIOD(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .par_in(par_in_b), .load_valid(load_valid_b),
    .load_ready(load_ready_b), .abort(abort_b), .ser_out(ser_out_b),
    .ser_clk(ser_clk_b), .latch(latch_b), .done(done_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0] v;
    int         c;
  } bit_exp_t;

  bit_exp_t qa_bit[$];
  bit_exp_t qb_bit[$];
  int qa_latch[$], qb_latch[$], qa_done[$], qb_done[$];

  // Monitor A
  bit_exp_t ea;
  logic pa_clk = 1'b0, pa_latch = 1'b0;
  int   ra_clk = 0, ra_latch = 0;
  always @(negedge clk) begin
    if (ser_clk_a && !pa_clk) begin
      ra_clk <= cyc;
      if (qa_bit.size() == 0) check("a_unexpected_rise", 1, 0);
      else begin
        ea = qa_bit.pop_front();
        check("a_bit", ser_out_a, ea.v);
        check("a_rise_cycle", cyc, ea.c);
      end
    end
    if (!ser_clk_a && pa_clk) check("a_clk_high_len", cyc - ra_clk, 1);
    if (latch_a && !pa_latch) begin
      ra_latch <= cyc;
      if (qa_latch.size() == 0) check("a_unexpected_latch", 1, 0);
      else check("a_latch_cycle", cyc, qa_latch.pop_front());
    end
    if (!latch_a && pa_latch) check("a_latch_len", cyc - ra_latch, 1);
    if (done_a) begin
      if (qa_done.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        check("a_done_cycle", cyc, qa_done.pop_front());
        check("a_done_ser_out", ser_out_a, 0);
        check("a_done_ready", load_ready_a, 1);
      end
    end
    pa_clk   <= ser_clk_a;
    pa_latch <= latch_a;
  end

  // Monitor B
  bit_exp_t eb;
  logic pb_clk = 1'b0, pb_latch = 1'b0;
  int   rb_clk = 0, rb_latch = 0;
  always @(negedge clk) begin
    if (ser_clk_b && !pb_clk) begin
      rb_clk <= cyc;
      if (qb_bit.size() == 0) check("b_unexpected_rise", 1, 0);
      else begin
        eb = qb_bit.pop_front();
        check("b_lanes", ser_out_b, eb.v);
        check("b_rise_cycle", cyc, eb.c);
      end
    end
    if (!ser_clk_b && pb_clk) check("b_clk_high_len", cyc - rb_clk, 3);
    if (latch_b && !pb_latch) begin
      rb_latch <= cyc;
      if (qb_latch.size() == 0) check("b_unexpected_latch", 1, 0);
      else check("b_latch_cycle", cyc, qb_latch.pop_front());
    end
    if (!latch_b && pb_latch) check("b_latch_len", cyc - rb_latch, 3);
    if (done_b) begin
      if (qb_done.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        check("b_done_cycle", cyc, qb_done.pop_front());
        check("b_done_ser_out", ser_out_b, 0);
        check("b_done_ready", load_ready_b, 1);
      end
    end
    pb_clk   <= ser_clk_b;
    pb_latch <= latch_b;
  end

  // seq holds the serial order with the first bit at [7]; call on a negedge.
  task automatic send_a(input logic [7:0] w, input logic [7:0] seq, input int nbits,
                        input bit full, output int e);
    par_in_a     = w;
    load_valid_a = 1'b1;
    #1;
    check("a_ready_at_offer", load_ready_a, 1);
    @(posedge clk);
    #1;
    e            = cyc;
    load_valid_a = 1'b0;
    par_in_a     = '0;
    for (int k = 0; k < nbits; k++) qa_bit.push_back('{v: {2'b00, seq[7-k]}, c: e + 2*k + 1});
    if (full) begin
      qa_latch.push_back(e + 16);
      qa_done.push_back(e + 17);
    end
  endtask

  task automatic send_b(input logic [11:0] w, input logic [2:0] t0, input logic [2:0] t1,
                        input logic [2:0] t2, input logic [2:0] t3, output int e);
    par_in_b     = w;
    load_valid_b = 1'b1;
    #1;
    check("b_ready_at_offer", load_ready_b, 1);
    @(posedge clk);
    #1;
    e            = cyc;
    load_valid_b = 1'b0;
    par_in_b     = '0;
    qb_bit.push_back('{v: t0, c: e + 3});
    qb_bit.push_back('{v: t1, c: e + 9});
    qb_bit.push_back('{v: t2, c: e + 15});
    qb_bit.push_back('{v: t3, c: e + 21});
    qb_latch.push_back(e + 24);
    qb_done.push_back(e + 27);
  endtask

  logic [7:0] seq_a;
  int e1, e2, e3, e4, guard;

  initial begin
`ifdef PISO_LSB_FIRST_EN
    seq_a = 8'b01110101;
`else
    seq_a = 8'b10101110;
`endif
    reset_n      = 1'b0;
    par_in_a     = '0;
    load_valid_a = 1'b0;
    abort_a      = 1'b0;
    par_in_b     = '0;
    load_valid_b = 1'b0;
    abort_b      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ser_out", ser_out_a, 0);
    check("rst_ser_clk", ser_clk_a, 0);
    check("rst_latch", latch_a, 0);
    check("rst_done", done_a, 0);
    check("rst_load_ready", load_ready_a, 1);
    check("rst_b_ser_out", ser_out_b, 0);
    check("rst_b_load_ready", load_ready_b, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer, then 8'hFF offered in the done cycle.
    send_a(8'b10101110, seq_a, 8, 1'b1, e1);
    while (cyc != e1 + 17) @(negedge clk);
    send_a(8'hFF, 8'hFF, 8, 1'b1, e2);
    while (cyc != e2 + 18) @(negedge clk);

    // Abort during the third HIGH phase.
    send_a(8'b10101110, seq_a, 3, 1'b0, e3);
    while (cyc != e3 + 5) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    check("abort_ser_out", ser_out_a, 0);
    check("abort_ser_clk", ser_clk_a, 0);
    check("abort_latch", latch_a, 0);
    check("abort_done", done_a, 0);
    check("abort_ready_low", load_ready_a, 0);
    load_valid_a = 1'b1;
    par_in_a     = 8'hFF;
    #1;
    check("abort_idle_ready", load_ready_a, 0);
    repeat (2) @(negedge clk);
    check("abort_idle_no_capture", ser_clk_a, 0);
    abort_a      = 1'b0;
    load_valid_a = 1'b0;
    par_in_a     = '0;
    #1;
    check("post_abort_ready", load_ready_a, 1);
    repeat (20) @(negedge clk);

    // Three lanes with divider: 12'hA5C.
`ifdef PISO_LSB_FIRST_EN
    send_b(12'hA5C, 3'b010, 3'b100, 3'b011, 3'b101, e4);
`else
    send_b(12'hA5C, 3'b101, 3'b011, 3'b100, 3'b010, e4);
`endif
    while (cyc != e4 + 30) @(negedge clk);

    guard = 0;
    while ((qa_bit.size() + qb_bit.size() + qa_latch.size() + qb_latch.size() +
            qa_done.size() + qb_done.size()) != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("qa_bit_drained", qa_bit.size(), 0);
    check("qb_bit_drained", qb_bit.size(), 0);
    check("qa_latch_drained", qa_latch.size(), 0);
    check("qb_latch_drained", qb_latch.size(), 0);
    check("qa_done_drained", qa_done.size(), 0);
    check("qb_done_drained", qb_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
